axi_cfg_arbiter: RTL

//  Round-robin arbiter that shares the single AXI-lite config-space master port among NUM_REQ requesters.

---
 rtl/dma_axi_arb_pkg.sv | 15 +
 rtl/axi_rr_pick.sv | 46 ++++
 rtl/axi_cfg_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dma_axi_arb_pkg.sv
// Shared definitions for the AXI-lite config-space arbiter and its round-robin picker.
// Holds the arbiter state encoding and the read/write op codes.
package dma_axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr is bit 0,
// take the lowest set bit, then map that position back to a requester index.
module axi_rr_pick
   import dma_axi_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

   // Modulo NUM_REQ for sums of two in-range indices (never exceeds 2*NUM_REQ-2).
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] v);
      logic [IDX_W:0] r;
      r = (v >= NUM_W) ? (v - NUM_W) : v;
      return r[IDX_W-1:0];
   endfunction

   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   rot_pos;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign rot[gi] = req[wrap_idx({1'b0, rr_ptr} + (IDX_W+1)'(gi))];
      end
   endgenerate

   always_comb begin
      rot_pos = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            rot_pos = IDX_W'(i);
         end
      end
   end

   assign any = |req;
   assign idx = wrap_idx({1'b0, rot_pos} + {1'b0, rr_ptr});

endmodule

// File: rtl/axi_cfg_arbiter.sv
// Round-robin arbiter sharing one AXI-lite config master among NUM_REQ requesters.
// One transaction at a time: grant, single go pulse, wait for done/error, one-cycle response.
module axi_cfg_arbiter
   import dma_axi_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                  axi_clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    resp_valid,
   output logic                  resp_error,
   output logic [31:0]           resp_rdata,
   output logic [31:0]           axi_rdwr_addr,
   output logic [31:0]           axi_wr_data,
   output logic                  axi_rd_go,
   output logic                  axi_wr_go,
   input  logic [31:0]           axi_rd_data,
   input  logic                  axi_rd_done,
   input  logic                  axi_wr_done,
   input  logic                  axi_error,
   output logic                  busy,
   output logic [IDX_W-1:0]      grant_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               op_q, op_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rd_go_q, rd_go_d;
   logic               wr_go_q, wr_go_d;
   logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
   logic               resp_error_q, resp_error_d;
   logic               busy_q, busy_d;

   logic               pick_any;
   logic [IDX_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] grant_onehot;
   logic               op_done;
   logic [31:0]        addr_arr  [NUM_REQ];
   logic [31:0]        wdata_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[32*gi +: 32];
         assign wdata_arr[gi] = req_wdata[32*gi +: 32];
      end
   endgenerate

   axi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_q),
      .any    (pick_any),
      .idx    (pick_idx)
   );

   assign grant_onehot = NUM_REQ'(1) << grant_q;
   // wr_done also strobes on reads, so completion is qualified by the captured op.
   assign op_done      = (op_q == OP_WR) ? axi_wr_done : axi_rd_done;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      rd_go_d      = 1'b0;
      wr_go_d      = 1'b0;
      resp_valid_d = '0;
      resp_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = ISSUE;
               grant_d = pick_idx;
               op_d    = req_wr[pick_idx] ? OP_WR : OP_RD;
               addr_d  = addr_arr[pick_idx];
               wdata_d = wdata_arr[pick_idx];
               rd_go_d = !req_wr[pick_idx];
               wr_go_d = req_wr[pick_idx];
            end
         end
         ISSUE: begin
            if (axi_error) begin
               state_d      = RESP;
               resp_valid_d = grant_onehot;
               resp_error_d = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (axi_error) begin
               state_d      = RESP;
               resp_valid_d = grant_onehot;
               resp_error_d = 1'b1;
            end else if (op_done) begin
               state_d      = RESP;
               resp_valid_d = grant_onehot;
               if (op_q == OP_RD) begin
                  rdata_d = axi_rd_data;
               end
            end
         end
         RESP: begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge axi_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         op_q         <= OP_RD;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         rd_go_q      <= 1'b0;
         wr_go_q      <= 1'b0;
         resp_valid_q <= '0;
         resp_error_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         rd_go_q      <= rd_go_d;
         wr_go_q      <= wr_go_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         busy_q       <= busy_d;
      end
   end

   assign resp_valid    = resp_valid_q;
   assign resp_error    = resp_error_q;
   assign resp_rdata    = rdata_q;
   assign axi_rdwr_addr = addr_q;
   assign axi_wr_data   = wdata_q;
   assign axi_rd_go     = rd_go_q;
   assign axi_wr_go     = wr_go_q;
   assign busy          = busy_q;
   assign grant_idx     = grant_q;

endmodule
